// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the issue-stage register scoreboard.
package reg_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use_rs1;
        logic                  use_rs2;
    } iss_req_t;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// In-flight write counter for one architectural register; clamps to zero on underflow.
module sb_counter #(
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic [1:0]           dec,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 underflow
);

    localparam int W = CNT_WIDTH + 1;

    logic [W-1:0] sum;
    logic [W-1:0] dec_ext;

    assign sum       = {1'b0, cnt} + W'(inc);
    assign dec_ext   = W'(dec);
    assign underflow = !clear && (dec_ext > sum);

    always_ff @(posedge clk) begin
        if (!rst_n || clear || underflow) begin
            cnt <= '0;
        end else begin
            cnt <= CNT_WIDTH'(sum - dec_ext);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Dual-issue scoreboard: per-register in-flight write counters gating RAW/WAW hazards.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int ADDRESS_WIDTH = REG_ADDR_W,
    parameter int CNT_WIDTH     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        iss0_valid,
    input  logic                        iss0_we,
    input  logic [ADDRESS_WIDTH-1:0]    iss0_rd,
    input  logic [ADDRESS_WIDTH-1:0]    iss0_rs1,
    input  logic [ADDRESS_WIDTH-1:0]    iss0_rs2,
    input  logic                        iss0_use_rs1,
    input  logic                        iss0_use_rs2,
    input  logic                        iss1_valid,
    input  logic                        iss1_we,
    input  logic [ADDRESS_WIDTH-1:0]    iss1_rd,
    input  logic [ADDRESS_WIDTH-1:0]    iss1_rs1,
    input  logic [ADDRESS_WIDTH-1:0]    iss1_rs2,
    input  logic                        iss1_use_rs1,
    input  logic                        iss1_use_rs2,
    input  logic                        wb0_valid,
    input  logic [ADDRESS_WIDTH-1:0]    wb0_rd,
    input  logic                        wb1_valid,
    input  logic [ADDRESS_WIDTH-1:0]    wb1_rd,
    input  logic                        flush,
    output logic                        grant0,
    output logic                        grant1,
    output logic [2**ADDRESS_WIDTH-1:0] busy_mask,
    output logic                        sb_err
);

    localparam int NR = 2 ** ADDRESS_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    iss_req_t s0, s1;
    logic [CNT_WIDTH-1:0] cnt [NR];
    logic [NR-1:0] busy;
    logic [NR-1:0] uflow;
    logic ok0, ok1, pair_raw, pair_waw;

    assign s0 = '{valid: iss0_valid, we: iss0_we, rd: iss0_rd, rs1: iss0_rs1,
                  rs2: iss0_rs2, use_rs1: iss0_use_rs1, use_rs2: iss0_use_rs2};
    assign s1 = '{valid: iss1_valid, we: iss1_we, rd: iss1_rd, rs1: iss1_rs1,
                  rs2: iss1_rs2, use_rs1: iss1_use_rs1, use_rs2: iss1_use_rs2};

    // x0 has no counter: it is permanently idle and can never reach the max
    assign cnt[0]   = '0;
    assign busy[0]  = 1'b0;
    assign uflow[0] = 1'b0;

    assign ok0 = s0.valid && !(s0.use_rs1 && busy[s0.rs1]) && !(s0.use_rs2 && busy[s0.rs2])
                 && !(s0.we && cnt[s0.rd] == CNT_MAX);
    assign ok1 = s1.valid && !(s1.use_rs1 && busy[s1.rs1]) && !(s1.use_rs2 && busy[s1.rs2])
                 && !(s1.we && cnt[s1.rd] == CNT_MAX);

    assign pair_raw = s0.we && (s0.rd != '0)
                      && ((s1.use_rs1 && s1.rs1 == s0.rd) || (s1.use_rs2 && s1.rs2 == s0.rd));
    assign pair_waw = s0.we && s1.we && (s0.rd != '0) && (s0.rd == s1.rd);

    assign grant0 = rst_n && !flush && ok0;
    assign grant1 = grant0 && ok1 && !pair_raw && !pair_waw;

    for (genvar r = 1; r < NR; r++) begin : g_cnt
        logic       inc;
        logic [1:0] dec;

        assign inc = (grant0 && s0.we && s0.rd == ADDRESS_WIDTH'(r))
                     || (grant1 && s1.we && s1.rd == ADDRESS_WIDTH'(r));
        assign dec = {1'b0, wb0_valid && wb0_rd == ADDRESS_WIDTH'(r)}
                     + {1'b0, wb1_valid && wb1_rd == ADDRESS_WIDTH'(r)};

        sb_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc),
            .dec       (dec),
            .clear     (flush),
            .cnt       (cnt[r]),
            .underflow (uflow[r])
        );

        assign busy[r] = |cnt[r];
    end

    assign busy_mask = busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_err <= 1'b0;
        end else if (|uflow) begin
            sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed plus random checks of reg_scoreboard against a counter-array reference model.
module tb_reg_scoreboard;

    localparam int AW   = 5;
    localparam int NR   = 32;
    localparam int MAXC = 3;

    logic clk, rst_n;
    logic iss0_valid, iss0_we, iss0_use_rs1, iss0_use_rs2;
    logic [AW-1:0] iss0_rd, iss0_rs1, iss0_rs2;
    logic iss1_valid, iss1_we, iss1_use_rs1, iss1_use_rs2;
    logic [AW-1:0] iss1_rd, iss1_rs1, iss1_rs2;
    logic wb0_valid, wb1_valid, flush;
    logic [AW-1:0] wb0_rd, wb1_rd;
    logic grant0, grant1, sb_err;
    logic [NR-1:0] busy_mask;

    int mcnt [NR];
    bit merr;
    int n_checks = 0;
    int n_fail = 0;
    logic g0_seen, g1_seen;

    reg_scoreboard #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss0_valid(iss0_valid), .iss0_we(iss0_we), .iss0_rd(iss0_rd),
        .iss0_rs1(iss0_rs1), .iss0_rs2(iss0_rs2),
        .iss0_use_rs1(iss0_use_rs1), .iss0_use_rs2(iss0_use_rs2),
        .iss1_valid(iss1_valid), .iss1_we(iss1_we), .iss1_rd(iss1_rd),
        .iss1_rs1(iss1_rs1), .iss1_rs2(iss1_rs2),
        .iss1_use_rs1(iss1_use_rs1), .iss1_use_rs2(iss1_use_rs2),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
        .flush(flush),
        .grant0(grant0), .grant1(grant1),
        .busy_mask(busy_mask), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit slot_ok(bit v, bit we, int rd, int rs1, int rs2, bit u1, bit u2);
        return v && !(u1 && mcnt[rs1] != 0) && !(u2 && mcnt[rs2] != 0)
               && !(we && rd != 0 && mcnt[rd] == MAXC);
    endfunction

    // One cycle: check the model's view before the edge, then advance the model.
    task automatic step();
        bit e0, e1, raw, waw;
        logic [31:0] eb;
        int n, d, i;
        #3;
        e0  = rst_n && !flush && slot_ok(iss0_valid, iss0_we, iss0_rd, iss0_rs1, iss0_rs2,
                                         iss0_use_rs1, iss0_use_rs2);
        raw = iss0_we && iss0_rd != 0 && ((iss1_use_rs1 && iss1_rs1 == iss0_rd)
                                          || (iss1_use_rs2 && iss1_rs2 == iss0_rd));
        waw = iss0_we && iss1_we && iss0_rd != 0 && iss0_rd == iss1_rd;
        e1  = e0 && !raw && !waw && slot_ok(iss1_valid, iss1_we, iss1_rd, iss1_rs1, iss1_rs2,
                                            iss1_use_rs1, iss1_use_rs2);
        for (int r = 0; r < NR; r++) eb[r] = (mcnt[r] != 0);
        chk("grant0", grant0, e0);
        chk("grant1", grant1, e1);
        chk("busy_mask", busy_mask, eb);
        chk("sb_err", sb_err, merr);
        g0_seen = grant0;
        g1_seen = grant1;
        @(posedge clk);
        if (!rst_n) begin
            foreach (mcnt[r]) mcnt[r] = 0;
            merr = 0;
        end else if (flush) begin
            foreach (mcnt[r]) mcnt[r] = 0;
        end else begin
            for (int r = 1; r < NR; r++) begin
                d = int'(wb0_valid && wb0_rd == r) + int'(wb1_valid && wb1_rd == r);
                i = int'((e0 && iss0_we && iss0_rd == r) || (e1 && iss1_we && iss1_rd == r));
                n = mcnt[r] + i - d;
                if (n < 0) begin
                    n = 0;
                    merr = 1;
                end
                mcnt[r] = n;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst_n = 1; flush = 0;
        iss0_valid = 0; iss0_we = 0; iss0_rd = 0; iss0_rs1 = 0; iss0_rs2 = 0;
        iss0_use_rs1 = 0; iss0_use_rs2 = 0;
        iss1_valid = 0; iss1_we = 0; iss1_rd = 0; iss1_rs1 = 0; iss1_rs2 = 0;
        iss1_use_rs1 = 0; iss1_use_rs2 = 0;
        wb0_valid = 0; wb0_rd = 0; wb1_valid = 0; wb1_rd = 0;
    endtask

    task automatic set0(bit v, bit we, int rd, int rs1, int rs2, bit u1, bit u2);
        iss0_valid = v; iss0_we = we; iss0_rd = AW'(rd); iss0_rs1 = AW'(rs1);
        iss0_rs2 = AW'(rs2); iss0_use_rs1 = u1; iss0_use_rs2 = u2;
    endtask

    task automatic set1(bit v, bit we, int rd, int rs1, int rs2, bit u1, bit u2);
        iss1_valid = v; iss1_we = we; iss1_rd = AW'(rd); iss1_rs1 = AW'(rs1);
        iss1_rs2 = AW'(rs2); iss1_use_rs1 = u1; iss1_use_rs2 = u2;
    endtask

    initial begin
        foreach (mcnt[r]) mcnt[r] = 0;
        merr = 0;
        idle();
        rst_n = 0;
        set0(1, 1, 5, 0, 0, 0, 0);
        step();
        chk("rst_grant0", g0_seen, 0);
        step();
        chk("rst_busy", busy_mask, 0);
        chk("rst_err", sb_err, 0);

        // addi x5, then retire it
        idle(); set0(1, 1, 5, 0, 0, 0, 0); step();
        chk("addi_grant0", g0_seen, 1);
        chk("addi_busy5", busy_mask[5], 1);
        idle(); wb0_valid = 1; wb0_rd = 5; step();
        chk("wb_busy5_clr", busy_mask[5], 0);

        // RAW on pending x5; same-cycle writeback must not bypass
        idle(); set0(1, 1, 5, 0, 0, 0, 0); step();
        idle(); set0(1, 0, 0, 5, 0, 1, 0); set1(1, 0, 0, 0, 0, 0, 0); step();
        chk("raw_g0", g0_seen, 0);
        chk("raw_g1", g1_seen, 0);
        step();
        chk("raw_g0_hold", g0_seen, 0);
        wb1_valid = 1; wb1_rd = 5; step();
        chk("no_bypass_g0", g0_seen, 0);
        wb1_valid = 0; step();
        chk("raw_release_g0", g0_seen, 1);

        // intra-pair RAW and WAW
        idle(); set0(1, 1, 7, 0, 0, 0, 0); set1(1, 0, 0, 0, 7, 0, 1); step();
        chk("pair_raw_g0", g0_seen, 1);
        chk("pair_raw_g1", g1_seen, 0);
        idle(); wb0_valid = 1; wb0_rd = 7; step();
        idle(); set0(1, 1, 9, 0, 0, 0, 0); set1(1, 1, 9, 0, 0, 0, 0); step();
        chk("pair_waw_g0", g0_seen, 1);
        chk("pair_waw_g1", g1_seen, 0);
        idle(); wb0_valid = 1; wb0_rd = 9; step();

        // counter limit on x3, then double writeback
        for (int k = 0; k < 3; k++) begin
            idle(); set0(1, 1, 3, 0, 0, 0, 0); step();
            chk("x3_fill_g0", g0_seen, 1);
        end
        step();
        chk("x3_full_g0", g0_seen, 0);
        idle(); wb0_valid = 1; wb0_rd = 3; wb1_valid = 1; wb1_rd = 3; step();
        chk("x3_dual_wb_busy", busy_mask[3], 1);
        idle(); wb0_valid = 1; wb0_rd = 3; step();
        chk("x3_last_wb_busy", busy_mask[3], 0);

        // inc and dec in one cycle net out
        idle(); set0(1, 1, 4, 0, 0, 0, 0); step();
        wb0_valid = 1; wb0_rd = 4; step();
        chk("x4_net_g0", g0_seen, 1);
        chk("x4_net_busy", busy_mask[4], 1);
        idle(); wb0_valid = 1; wb0_rd = 4; step();
        chk("x4_clr_busy", busy_mask[4], 0);

        // underflow is sticky
        idle(); wb0_valid = 1; wb0_rd = 6; step();
        chk("uflow_err", sb_err, 1);
        idle(); step();
        chk("uflow_err_hold", sb_err, 1);

        // flush clears everything
        idle(); set0(1, 1, 2, 0, 0, 0, 0); set1(1, 1, 8, 0, 0, 0, 0); step();
        chk("pre_flush_g1", g1_seen, 1);
        idle(); flush = 1; set0(1, 1, 10, 0, 0, 0, 0); set1(1, 1, 11, 0, 0, 0, 0); step();
        chk("flush_g0", g0_seen, 0);
        chk("flush_g1", g1_seen, 0);
        chk("flush_busy", busy_mask, 0);

        // x0 never tracked
        for (int k = 0; k < 4; k++) begin
            idle(); set0(1, 1, 0, 0, 0, 1, 1); set1(1, 1, 0, 0, 0, 1, 1); step();
            chk("x0_g1", g1_seen, 1);
            chk("x0_busy", busy_mask[0], 0);
        end

        idle(); rst_n = 0; step();
        idle(); step();

        // random traffic on a small register window to provoke hazards
        for (int c = 0; c < 500; c++) begin
            idle();
            rst_n = ($urandom_range(0, 63) != 0);
            flush = ($urandom_range(0, 31) == 0);
            set0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            set1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            wb0_rd = AW'($urandom_range(0, 7));
            wb1_rd = AW'($urandom_range(0, 7));
            wb0_valid = !flush && (mcnt[wb0_rd] != 0 || $urandom_range(0, 15) == 0)
                        && $urandom_range(0, 1) == 1;
            wb1_valid = !flush && (mcnt[wb1_rd] != 0 || $urandom_range(0, 15) == 0)
                        && $urandom_range(0, 1) == 1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
